// File: rtl/parity_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Define PARITY_TX_PARITY_EN to compile in the parity bit and PARITY state.
module parity_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef PARITY_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state, state_next;
  logic [CNT_W-1:0]   clk_cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic [DATA_W-1:0]  shift_reg;
  logic [DATA_W-1:0]  shift_next;
  logic               bit_end;
  logic               last_bit;
`ifdef PARITY_TX_PARITY_EN
  logic               parity_bit;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    bit_end    = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    last_bit   = (bit_idx == IDX_W'(DATA_W - 1));
    shift_next = shift_reg >> 1;
    case (state)
      IDLE:   if (valid_in) state_next = START;
      START:  if (bit_end) state_next = DATA;
`ifdef PARITY_TX_PARITY_EN
      DATA:   if (bit_end && last_bit) state_next = PARITY;
      PARITY: if (bit_end) state_next = STOP;
`else
      DATA:   if (bit_end && last_bit) state_next = STOP;
`endif
      STOP:   if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready_out = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == STOP) && bit_end;

  // tx is loaded with the value of the upcoming bit on the edge that enters it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      tx         <= 1'b1;
`ifdef PARITY_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (state == IDLE) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      if (valid_in) begin
        shift_reg  <= data_in;
        tx         <= 1'b0;
`ifdef PARITY_TX_PARITY_EN
        parity_bit <= ^data_in;
`endif
      end
    end else begin
      if (bit_end) clk_cnt <= '0;
      else         clk_cnt <= clk_cnt + CNT_W'(1);
      case (state)
        START: if (bit_end) tx <= shift_reg[0];
        DATA: begin
          if (bit_end) begin
            if (last_bit) begin
              bit_idx <= '0;
`ifdef PARITY_TX_PARITY_EN
              tx      <= parity_bit;
`else
              tx      <= 1'b1;
`endif
            end else begin
              bit_idx   <= bit_idx + IDX_W'(1);
              shift_reg <= shift_next;
              tx        <= shift_next[0];
            end
          end
        end
`ifdef PARITY_TX_PARITY_EN
        PARITY: if (bit_end) tx <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_tx.sv
// Directed bench for parity_tx (DATA_W=8, CLKS_PER_BIT=4); follows PARITY_TX_PARITY_EN
// to pick the frame layout it expects.
module tb_parity_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef PARITY_TX_PARITY_EN
  localparam int BITS = DW + 3;
`else
  localparam int BITS = DW + 2;
`endif
  localparam int FLEN = BITS * CPB;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_out;
  logic          tx;
  logic          busy;
  logic          done;

  int compared   = 0;
  int mismatched = 0;

  parity_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Serial bit expected on tx during cycle k (1-based) after the accepting edge
  function automatic logic expectedTx(input logic [DW-1:0] d, input int k);
    int b;
    b = (k - 1) / CPB;
    if (b == 0)  return 1'b0;
    if (b <= DW) return d[b-1];
`ifdef PARITY_TX_PARITY_EN
    if (b == DW + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  // Offer a payload at the next negedge and leave the bench just after the accepting edge
  task automatic applyStimulus(input logic [DW-1:0] d, input logic after_data, input logic hold_valid);
    @(negedge clk);
    data_in  = d;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    data_in  = after_data;
    valid_in = hold_valid;
  endtask

  // Check cycles 1..last_k of a frame; optionally pulse valid_in across the edge after pulse_k
  task automatic checkFrame(input string name, input logic [DW-1:0] d, input int last_k, input int pulse_k);
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s tx c%0d", name, k), tx, expectedTx(d, k));
      checkOutput($sformatf("%s busy c%0d", name, k), busy, 1);
      checkOutput($sformatf("%s ready c%0d", name, k), ready_out, 0);
      checkOutput($sformatf("%s done c%0d", name, k), done, (k == FLEN));
      if (pulse_k != 0 && k == pulse_k) valid_in = 1'b1;
      if (pulse_k != 0 && k == pulse_k + 1) valid_in = 1'b0;
    end
  endtask

  task automatic checkIdle(input string name);
    @(negedge clk);
    checkOutput({name, " tx"}, tx, 1);
    checkOutput({name, " busy"}, busy, 0);
    checkOutput({name, " ready"}, ready_out, 1);
    checkOutput({name, " done"}, done, 0);
  endtask

  initial begin
    reset_n  = 1'b0;
    data_in  = '0;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    checkIdle("reset");
    reset_n = 1'b1;
    checkIdle("post-reset");

    // Single frame 0xA5; data_in changes right after accept
    applyStimulus(8'hA5, 8'h00, 1'b0);
    checkFrame("A5", 8'hA5, FLEN, 0);
    checkIdle("A5 gap");

    // Back-to-back 0x01 then 0x00 with valid_in held high throughout
    applyStimulus(8'h01, 8'h00, 1'b1);
    checkFrame("B01", 8'h01, FLEN, 0);
    checkIdle("B2B gap");
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    checkFrame("B00", 8'h00, FLEN, 0);
    checkIdle("B00 gap");

    // 0xFF with data_in cleared and a stray valid pulse mid-frame
    applyStimulus(8'hFF, 8'h00, 1'b0);
    checkFrame("FF", 8'hFF, FLEN, 9);
    checkIdle("FF gap");
    checkIdle("FF no-second");

    // Reset mid-frame, with valid_in asserted while reset is held
    applyStimulus(8'h3C, 8'h00, 1'b0);
    checkFrame("3C", 8'h3C, 19, 0);
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    valid_in = 1'b1;
    #1;
    checkOutput("abort tx", tx, 1);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort ready", ready_out, 1);
    checkOutput("abort done", done, 0);
    repeat (2) @(posedge clk);
    checkIdle("in-reset");
    valid_in = 1'b0;
    reset_n  = 1'b1;
    checkIdle("after-abort");
    applyStimulus(8'h81, 8'h00, 1'b0);
    checkFrame("81", 8'h81, FLEN, 0);
    checkIdle("81 gap");

    // Bit pattern with only the MSB set
    applyStimulus(8'h80, 8'h00, 1'b0);
    checkFrame("80", 8'h80, FLEN, 0);
    checkIdle("80 gap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/parity_tx.md
PARITY_TX -- requirements
Module: parity_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (legal 1..32).
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles each serial bit is held (legal >= 1).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 data_in  input  DATA_W  payload, sampled on the accepting edge.
REQ-007 valid_in  input  1  payload offered.
REQ-008 ready_out  output  1  block can accept a payload this cycle.
REQ-009 tx  output  1  serial line, idle high.
REQ-010 busy  output  1  frame in progress.
REQ-011 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-012 Frame SHALL be start bit (0), DATA_W data bits LSB first, parity bit, stop bit (1); each bit is held on tx for exactly CLKS_PER_BIT cycles.
REQ-013 Parity bit SHALL be the XOR of all DATA_W captured data bits (even parity).
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; IDLE->START on accept, START->DATA after CLKS_PER_BIT, DATA->PARITY after DATA_W bit periods, PARITY->STOP after one bit period, STOP->IDLE after one bit period.
REQ-015 ready_out SHALL be 1 only in IDLE; accept occurs on a rising edge where valid_in && ready_out.
REQ-016 data_in SHALL be captured into an internal shift register on accept; later changes to data_in SHALL NOT affect the frame in flight.
REQ-017 tx SHALL drive the start bit in the first cycle after the accepting edge (latency 1 cycle).
REQ-018 valid_in while busy SHALL be ignored; no queuing, no corruption of the current frame.
REQ-019 busy SHALL be 1 in every non-IDLE state, 0 in IDLE.
REQ-020 done SHALL be 1 for exactly one cycle, the last cycle of the stop bit; 0 otherwise.
REQ-021 Back-to-back: after STOP the block spends at least one cycle in IDLE with ready_out=1 before the next start bit; consecutive frames are separated by exactly one idle-high cycle when valid_in is held high.
REQ-022 Bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap; bit index counter SHALL count 0..DATA_W-1; neither SHALL overflow for any legal parameter value.
REQ-023 tx SHALL be driven from a register (glitch-free).

Reset
REQ-024 On reset_n=0, immediately and asynchronously: state=IDLE, tx=1, ready_out=1, busy=0, done=0, counters and shift register cleared.
REQ-025 Reset asserted mid-frame SHALL abort the frame; after release the block is in IDLE and the next accept starts a complete new frame.
REQ-026 While reset_n=0, valid_in SHALL be ignored.

Configuration
REQ-027 Macro PARITY_TX_PARITY_EN: when defined, the PARITY state and parity bit are compiled in per REQ-012..014 (frame = DATA_W+3 bit periods).
REQ-028 Without PARITY_TX_PARITY_EN, PARITY state and parity logic SHALL be absent; DATA->STOP directly; frame = DATA_W+2 bit periods; all other behaviour unchanged.

Verification (DATA_W=8, CLKS_PER_BIT=4, macro defined unless stated)
REQ-029 Accept 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each 4 cycles; done pulses at cycle 44 after accept; busy high cycles 1..44.
REQ-030 Accept 0x01 then 0x00 with valid_in held high -> parity 1 then 0; exactly one idle-high cycle between frames; two done pulses 45 cycles apart.
REQ-031 Accept 0xFF, then change data_in to 0x00 and pulse valid_in at cycle 10 -> transmitted frame still 0xFF with parity 0; no second frame starts.
REQ-032 Accept 0x3C, assert reset_n=0 at cycle 20 -> tx=1, busy=0, ready_out=1 in the same cycle; after release accept 0x81 -> complete correct frame, parity 0.
REQ-033 Macro undefined, accept 0x80 -> tx 0,0,0,0,0,0,0,0,1,1(stop); done at cycle 40; no parity bit.
